// File: rtl/ftoi_pipe.sv
// Three-stage binary32 -> OUT_W-bit integer converter (unpack, align, round/pack); latency 3, one op/cycle.
// Whole pipe stalls when the output is held (in_ready = !out_valid || out_ready); FTOI_FLAGS_EN enables nv/nx.
module ftoi_pipe #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x,
  input  logic [2:0]       rm,
  input  logic             uns,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] y,
  output logic             nv,
  output logic             nx
);

  localparam int FW = OUT_W + 24;
  localparam int EW = 2 * FW;
  localparam logic [OUT_W-1:0] SMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] UMAX = {OUT_W{1'b1}};

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: unpack
  logic        v1, s1, uns1, zero1, nan1, inf1;
  logic [7:0]  e1;
  logic [22:0] m1;
  logic [2:0]  rm1;
  logic [8:0]  sh1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      s1    <= 1'b0;
      uns1  <= 1'b0;
      zero1 <= 1'b0;
      nan1  <= 1'b0;
      inf1  <= 1'b0;
      e1    <= '0;
      m1    <= '0;
      rm1   <= '0;
      sh1   <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1    <= x[31];
        e1    <= x[30:23];
        m1    <= x[22:0];
        rm1   <= rm;
        uns1  <= uns;
        zero1 <= (x[30:0] == 31'd0);
        nan1  <= (&x[30:23]) && (|x[22:0]);
        inf1  <= (&x[30:23]) && !(|x[22:0]);
        sh1   <= 9'(127 + OUT_W - 1) - {1'b0, x[30:23]};
      end
    end
  end

  // S2: align. Integer part lands in the top OUT_W bits of the upper half,
  // guard just below it, everything further down feeds sticky.
  logic [23:0]       sig1;
  logic [EW-1:0]     ext1, shf1;
  logic [OUT_W-1:0]  mag_d;
  logic              g_d, st_d, big_d;

  always_comb begin
    sig1  = {e1 != 8'd0, m1};
    ext1  = {sig1, {(EW-24){1'b0}}};
    shf1  = ext1 >> sh1[7:0];
    big_d = ({1'b0, e1} >= 9'(127 + OUT_W));
    mag_d = '0;
    g_d   = 1'b0;
    st_d  = 1'b0;
    if (!sh1[8]) begin
      if (sh1 >= 9'(FW)) begin
        st_d = !zero1;
      end else begin
        mag_d = shf1[EW-1 -: OUT_W];
        g_d   = shf1[EW-1-OUT_W];
        st_d  = |shf1[EW-2-OUT_W:0];
      end
    end
  end

  logic             v2, s2, uns2, nan2, inf2, big2, g2, st2;
  logic [2:0]       rm2;
  logic [OUT_W-1:0] mag2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      s2   <= 1'b0;
      uns2 <= 1'b0;
      nan2 <= 1'b0;
      inf2 <= 1'b0;
      big2 <= 1'b0;
      g2   <= 1'b0;
      st2  <= 1'b0;
      rm2  <= '0;
      mag2 <= '0;
    end else if (adv) begin
      v2 <= v1;
      if (v1) begin
        s2   <= s1;
        uns2 <= uns1;
        nan2 <= nan1;
        inf2 <= inf1;
        big2 <= big_d;
        g2   <= g_d;
        st2  <= st_d;
        rm2  <= rm1;
        mag2 <= mag_d;
      end
    end
  end

  // S3: round and pack
  logic             rup, in_rng;
  logic [OUT_W:0]   magr;
  logic [OUT_W-1:0] y_d;

  always_comb begin
    case (rm2)
      3'd0:    rup = g2 && (st2 || mag2[0]);
      3'd2:    rup = s2 && (g2 || st2);
      3'd3:    rup = !s2 && (g2 || st2);
      3'd4:    rup = g2;
      default: rup = 1'b0;
    endcase
    magr = {1'b0, mag2} + (OUT_W+1)'(rup);
    if (uns2)
      in_rng = s2 ? (magr == '0) : !magr[OUT_W];
    else
      in_rng = !magr[OUT_W] && (!magr[OUT_W-1] || (s2 && (magr[OUT_W-2:0] == '0)));
    if (nan2)
      y_d = uns2 ? UMAX : SMAX;
    else if (inf2 || big2 || !in_rng)
      y_d = uns2 ? (s2 ? '0 : UMAX) : (s2 ? SMIN : SMAX);
    else
      y_d = s2 ? -magr[OUT_W-1:0] : magr[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) y <= y_d;
    end
  end

`ifdef FTOI_FLAGS_EN
  logic nv_d, nx_d;

  always_comb begin
    nv_d = nan2 || inf2 || big2 || !in_rng;
    nx_d = !nv_d && (g2 || st2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nv <= 1'b0;
      nx <= 1'b0;
    end else if (adv && v2) begin
      nv <= nv_d;
      nx <= nx_d;
    end
  end
`else
  assign nv = 1'b0;
  assign nx = 1'b0;
`endif

endmodule

// File: doc/ftoi_pipe.md
# ftoi_pipe

Parametrised, pipelined single-precision float to integer converter for the FPU execute path. Adds signed/unsigned conversion, all five IEEE/RISC-V rounding modes, saturation with exception flags, a 32/64-bit result and a valid/ready handshake with backpressure. Three register stages; one conversion accepted per cycle when not stalled.

## Interface
- `OUT_W`, 32: result width; legal values 32 or 64.
- `clk` in 1: clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: operand valid.
- `in_ready` out 1: stage 1 can accept; transfer when `in_valid && in_ready`.
- `x` in 32: IEEE-754 binary32 operand.
- `rm` in 3: rounding mode. 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5–7 are treated as RTZ.
- `uns` in 1: 1 = unsigned result, 0 = two's-complement signed.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts; transfer when `out_valid && out_ready`.
- `y` out OUT_W: integer result.
- `nv` out 1: invalid flag for this result.
- `nx` out 1: inexact flag for this result.

## Operation
- S1 (unpack):
  - Register s/e/m, `rm`, `uns`.
  - Classify: zero (e=0, m=0); subnormal (e=0, m≠0); inf; NaN.
  - Compute `shift = (127+OUT_W-1) - e`, 9-bit signed.
- S2 (align):
  - Significand `{e!=0, m}` left-justified in an OUT_W+24-bit field.
  - Right shift by `shift`; when `shift ≥ OUT_W+24`, integer part is 0 and sticky = (significand≠0).
  - Produce integer magnitude, guard bit, sticky (OR of all lower bits).
  - Big flag = `e ≥ 127+OUT_W` (magnitude ≥ 2^OUT_W, cannot fit).
- S3 (round/pack):
  - Round up when:
    - RNE: g && (st || lsb).
    - RTZ: never.
    - RDN: s && (g||st).
    - RUP: !s && (g||st).
    - RMM: g.
  - Magnitude increment may carry to 2^OUT_W; keep OUT_W+1 bits.
  - Signed limits: max 2^(OUT_W-1)-1, min -2^(OUT_W-1); exactly -2^(OUT_W-1) is in range.
  - Unsigned limits: max 2^OUT_W-1, min 0. A negative input whose rounded magnitude is 0 gives 0 with nx only. Any nonzero negative rounded magnitude is out of range.
  - Out of range, inf or big: saturate to the limit on the sign's side, nv=1, nx=0.
  - NaN: result = positive max for the mode, nv=1.
  - In range: y = s ? -mag : mag; nv=0; nx = g||st.
  - Zero (±0): y=0, no flags. Subnormals are tiny nonzero values; they round per mode.

## Timing
- Latency: 3 cycles from input transfer to `out_valid`, with no backpressure.
- Pipeline stall: `adv = !out_valid || out_ready`. All three stages hold when `adv`=0; `in_ready = adv`.
- Each stage's valid bit moves forward with its data. Bubbles do not collapse.
- A held output keeps `y`, `nv`, `nx` stable until transfer.
- Throughput: 1 result/cycle when `out_ready` is held high.
- Reset:
  - Clears all stage valid bits immediately.
  - `out_valid`=0, `y`=0, `nv`=0, `nx`=0; `in_ready`=1 once out of reset.
  - Reset mid-operation discards in-flight conversions; nothing is emitted afterward for them.
- Simultaneous input transfer and output transfer in one cycle are both legal.

## Configuration
- `FTOI_FLAGS_EN` defined: `nv`/`nx` are computed as above and pipelined.
- Not defined: `nv`/`nx` are constant 0 and no flag logic is synthesised. `y` saturation behaviour is unchanged.

## Test plan
- OUT_W=32, signed, rounding:
  - x=0x40200000 (2.5), rm=RNE → y=2, nx=1.
  - Same x, rm=RUP → 3.
  - x=0xC0200000 (-2.5), rm=RMM → y=0xFFFFFFFD, nx=1.
- Overflow and NaN, signed, OUT_W=32:
  - x=0x4F32D05E (3e9) → y=0x7FFFFFFF, nv=1.
  - x=0xCF000000 (-2^31) → y=0x80000000, no flags.
  - x=0x7FC00000 → y=0x7FFFFFFF, nv=1.
- Unsigned, OUT_W=32:
  - x=0xBF000000 (-0.5), rm=RTZ → y=0, nx=1, nv=0.
  - x=0xBF800000 (-1.0) → y=0, nv=1.
  - x=0x4F32D05E → y=0xB2D05E00, no flags.
- OUT_W=64, signed:
  - x=0x5F000000 (2^63) → y=0x7FFFFFFFFFFFFFFF, nv=1.
  - x=0x3E800000 (0.25), rm=RUP → y=1, nx=1.
- Handshake:
  - Stream 8 operands back-to-back with `out_ready` low on cycles 4–6.
  - Results arrive in order, none lost or duplicated, and `in_ready` is low exactly while stalled.
  - Assert `rst` with 3 in flight → `out_valid`=0 immediately; no stale outputs afterward.
